// File: rtl/instr_word_encoder.sv
// Encodes symbolic instruction fields into 32-bit MIPS words and streams them into imem at load time.
// Optional INSTR_CHECKSUM_EN adds an XOR checksum of every word written in the current session.
module instr_word_encoder #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
`ifdef INSTR_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LastC  = DepthC - 1'b1;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
`ifdef INSTR_CHECKSUM_EN
    logic [31:0]       cks_q, cks_d;
`endif

    logic        legal;
    logic [31:0] enc;
    logic        accept;

    always_comb begin
        legal = 1'b1;
        enc   = '0;
        case (op_sel)
            4'd0:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h27};
            4'd5:    enc = {6'h00, rs, rt, rd, 5'd0, 6'h2a};
            4'd6:    enc = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
            4'd7:    enc = {6'h00, 5'd0, rt, rd, shamt, 6'h02};
            4'd8:    enc = {6'h23, rs, rt, imm};
            4'd9:    enc = {6'h2b, rs, rt, imm};
            4'd10:   enc = {6'h04, rs, rt, imm};
            4'd11:   enc = {6'h08, rs, rt, imm};
            4'd12:   enc = {6'h02, jaddr};
            default: legal = 1'b0;
        endcase
    end

    // Accepted-but-unwritten words never exist: count_q already includes the word on the bus.
    assign in_ready = (state_q == StLoad) && !start && (count_q < DepthC);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef INSTR_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        if (start) begin
            state_d = StLoad;
            count_d = '0;
            err_d   = 1'b0;
`ifdef INSTR_CHECKSUM_EN
            cks_d   = '0;
`endif
        end else begin
            if (accept) begin
                if (legal) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = enc;
                    count_d = count_q + 1'b1;
`ifdef INSTR_CHECKSUM_EN
                    cks_d   = cks_q ^ enc;
`endif
                    if (count_q == LastC) state_d = StDone;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (finish && state_q == StLoad) state_d = StDone;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef INSTR_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef INSTR_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    // A start arriving while a write is on the bus cancels that write.
    assign imem_we    = we_q && !start;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign done       = (state_q == StDone);
    assign err        = err_q;
`ifdef INSTR_CHECKSUM_EN
    assign checksum   = cks_q;
`endif

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: directed boundary cases plus random traffic
// compared every cycle against a behavioural model.
module tb_instr_word_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        op_sel = '0;
    logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]       imm = '0;
    logic [25:0]       jaddr = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              done, err;
`ifdef INSTR_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    instr_word_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .jaddr(jaddr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .done(done), .err(err)
`ifdef INSTR_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural encoding from the instruction-format tables.
    int unsigned functs[8]  = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h2a, 32'h00, 32'h02};
    int unsigned iops[4]    = '{32'h23, 32'h2b, 32'h04, 32'h08};

    function automatic logic [32:0] model_enc(input int unsigned op, input int unsigned f_rs,
        input int unsigned f_rt, input int unsigned f_rd, input int unsigned f_sh,
        input int unsigned f_imm, input int unsigned f_ja);
        int unsigned w;
        if (op < 8) begin
            if (op >= 6) f_rs = 0;
            else f_sh = 0;
            w = f_rs * (2**21) + f_rt * (2**16) + f_rd * (2**11) + f_sh * 64 + functs[op];
            return {1'b1, w};
        end else if (op < 12) begin
            w = iops[op-8] * (2**26) + f_rs * (2**21) + f_rt * (2**16) + f_imm;
            return {1'b1, w};
        end else if (op == 12) begin
            w = 2 * (2**26) + f_ja;
            return {1'b1, w};
        end
        return 33'd0;
    endfunction

    // Model: mode 0 idle, 1 loading, 2 closed.
    int          m_mode = 0;
    int          m_cnt  = 0;
    bit          m_err  = 0;
    bit          m_we   = 0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_cks  = '0;

    always @(posedge clk or posedge rst) begin
        logic [32:0] r;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = '0; m_cks = '0;
        end else if (start) begin
            m_mode = 1; m_cnt = 0; m_err = 0; m_we = 0; m_cks = '0;
        end else begin
            m_we = 0;
            if (in_valid && m_mode == 1 && m_cnt < DEPTH) begin
                r = model_enc(op_sel, rs, rt, rd, shamt, imm, jaddr);
                if (r[32]) begin
                    m_we = 1; m_addr = m_cnt % (2**ADDR_W); m_data = r[31:0];
                    m_cks ^= r[31:0];
                    m_cnt++;
                    if (m_cnt == DEPTH) m_mode = 2;
                end else begin
                    m_err = 1;
                end
            end
            if (finish && m_mode == 1) m_mode = 2;
        end
    end

    bit rec = 0;
    int wcount[2**ADDR_W];

    always @(negedge clk) begin
        chk("in_ready", in_ready, (m_mode == 1 && !start && m_cnt < DEPTH));
        chk("imem_we", imem_we, (m_we && !start));
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_data);
        chk("word_count", word_count, m_cnt);
        chk("done", done, (m_mode == 2));
        chk("err", err, m_err);
`ifdef INSTR_CHECKSUM_EN
        chk("checksum", checksum, m_cks);
`endif
        if (rec && imem_we) wcount[imem_addr]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op, input int a, input int b, input int c, input int s,
                          input int i, input int j);
        op_sel = 4'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(s);
        imm = 16'(i); jaddr = 26'(j);
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        logic [32:0] r;
        // Pin the model encoder to hand-computed words.
        r = model_enc(0, 1, 2, 3, 0, 0, 0);      chk("model_add", r, {1'b1, 32'h00221820});
        r = model_enc(6, 7, 2, 3, 4, 0, 0);      chk("model_sll", r, {1'b1, 32'h00021900});
        r = model_enc(8, 0, 8, 0, 0, 4, 0);      chk("model_lw", r, {1'b1, 32'h8C080004});
        r = model_enc(10, 1, 2, 0, 0, 16'hffff, 0); chk("model_beq", r, {1'b1, 32'h1022FFFF});
        r = model_enc(12, 0, 0, 0, 0, 0, 16);    chk("model_j", r, {1'b1, 32'h08000010});

        repeat (2) tick();
        chk("rst_we", imem_we, 0); chk("rst_cnt", word_count, 0); chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // start together with in_valid is not accepted.
        set_op(0, 1, 2, 3, 0, 0, 0);
        start = 1'b1; in_valid = 1'b1;
        #1 chk("start_ready", in_ready, 0);
        tick(); start = 1'b0;
        chk("start_noacc_cnt", word_count, 0);
        tick(); in_valid = 1'b0;
        chk("add_we", imem_we, 1); chk("add_addr", imem_addr, 0);
        chk("add_word", imem_wdata, 32'h00221820); chk("add_cnt", word_count, 1);
        set_op(8, 0, 8, 0, 0, 4, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("lw_word", imem_wdata, 32'h8C080004); chk("lw_addr", imem_addr, 1);
`ifdef INSTR_CHECKSUM_EN
        chk("cks_pair", checksum, 32'h8C2A1824);
`endif
        set_op(6, 7, 2, 3, 4, 0, 0); in_valid = 1'b1; tick();
        chk("sll_word", imem_wdata, 32'h00021900);
        set_op(10, 1, 2, 0, 0, 16'hffff, 0); tick();
        chk("beq_word", imem_wdata, 32'h1022FFFF);
        set_op(12, 0, 0, 0, 0, 0, 16); tick(); in_valid = 1'b0;
        chk("j_word", imem_wdata, 32'h08000010);
        tick();
        chk("hold_we", imem_we, 0); chk("hold_word", imem_wdata, 32'h08000010);
        chk("hold_addr", imem_addr, 4);

        // Illegal op: handshake completes, no write, err sticky until next start.
        set_op(14, 1, 1, 1, 1, 1, 1); in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("ill_we", imem_we, 0); chk("ill_err", err, 1); chk("ill_cnt", word_count, 5);
        do_start();
        chk("restart_err", err, 0); chk("restart_cnt", word_count, 0);

        // finish together with accept.
        set_op(1, 4, 5, 6, 0, 0, 0); in_valid = 1'b1; finish = 1'b1; tick();
        in_valid = 1'b0; finish = 1'b0;
        chk("fin_we", imem_we, 1); chk("fin_cnt", word_count, 1); chk("fin_done", done, 1);
        finish = 1'b1; tick(); finish = 1'b0;
        chk("fin_done_hold", done, 1);
        start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
        chk("start_wins", done, 0);

        // start with a write on the bus suppresses it.
        set_op(2, 1, 2, 3, 0, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        start = 1'b1;
        #1 chk("suppress_we", imem_we, 0);
        tick(); start = 1'b0;
        chk("suppress_cnt", word_count, 0);

        // Full-depth stream with in_valid held.
        for (int i = 0; i < 2**ADDR_W; i++) wcount[i] = 0;
        rec = 1'b1; in_valid = 1'b1;
        repeat (DEPTH + 6) begin
            set_op($urandom % 13, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            tick();
        end
        in_valid = 1'b0; tick(); tick(); rec = 1'b0;
        for (int i = 0; i < DEPTH; i++) chk($sformatf("stream_addr%0d", i), wcount[i], 1);
        chk("stream_done", done, 1); chk("stream_ready", in_ready, 0);
        chk("stream_cnt", word_count, DEPTH);

        // Reset right after an accept: no write must follow.
        do_start();
        set_op(0, 1, 2, 3, 0, 0, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_mid_we", imem_we, 0); chk("rst_mid_cnt", word_count, 0);
        tick(); rst = 1'b0; tick();

        // Random traffic against the model.
        repeat (3000) begin
            start    = ($urandom % 40 == 0);
            finish   = ($urandom % 30 == 0);
            in_valid = ($urandom % 10 < 7);
            if ($urandom % 8 == 0) op_sel = 4'(13 + $urandom % 3);
            else op_sel = 4'($urandom % 13);
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
            imm = 16'($urandom); jaddr = 26'($urandom);
            if ($urandom % 300 == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else begin
                tick();
            end
        end
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
